// File: rtl/beam_ctrl_pkg.sv
// Shared types and constants for the dual-beam threshold controller.
// Scaler build option: BEAM_SCALER_EN.
package beam_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMMIT
    } beam_state_e;

    localparam logic [1:0] CE_A    = 2'b10;
    localparam logic [1:0] CE_B    = 2'b01;
    localparam logic [1:0] CE_NONE = 2'b00;

    localparam int DEF_THRESH_BITS = 18;
    localparam int DEF_CNT_BITS    = 16;
    localparam int DEF_HOLDOFF     = 8;
    localparam int PERIOD_BITS     = 24;

endpackage

// File: rtl/beam_trig_scaler.sv
// Single-beam saturating trigger counter with synchronous clear.
// Used by dual_beam_thresh_ctrl when BEAM_SCALER_EN is defined.
module beam_trig_scaler #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                trig_i,
    input  logic                clr_i,
    output logic [CNT_BITS-1:0] sum_o
);

    logic [CNT_BITS-1:0] acc_q;

    // sum_o includes the current trigger so the final window cycle counts
    assign sum_o = (trig_i && !(&acc_q)) ? acc_q + CNT_BITS'(1) : acc_q;

    always_ff @(posedge clk) begin
        if (rst_i || clr_i || !en_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/dual_beam_thresh_ctrl.sv
// Loads A/B beam thresholds then commits them; optional windowed trigger
// scalers with post-update holdoff are built when BEAM_SCALER_EN is defined.
import beam_ctrl_pkg::*;

module dual_beam_thresh_ctrl #(
    parameter int THRESH_BITS = DEF_THRESH_BITS,
    parameter int CNT_BITS    = DEF_CNT_BITS,
    parameter int HOLDOFF     = DEF_HOLDOFF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [THRESH_BITS-1:0] req_thresh_a_i,
    input  logic [THRESH_BITS-1:0] req_thresh_b_i,
    output logic [THRESH_BITS-1:0] thresh_o,
    output logic [1:0]             thresh_ce_o,
    output logic                   update_o,
    input  logic [1:0]             trigger_i,
    input  logic [PERIOD_BITS-1:0] period_i,
    output logic [CNT_BITS-1:0]    count_a_o,
    output logic [CNT_BITS-1:0]    count_b_o,
    output logic                   count_valid_o
);

    beam_state_e            state_q, state_d;
    logic [THRESH_BITS-1:0] a_q, b_q, last_q;
    logic                   accept;

    assign req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= req_thresh_a_i;
                b_q <= req_thresh_b_i;
            end
            if (state_q == S_LOAD_B) begin
                last_q <= b_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        thresh_o    = last_q;
        thresh_ce_o = CE_NONE;
        update_o    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                thresh_o    = a_q;
                thresh_ce_o = CE_A;
                state_d     = S_LOAD_B;
            end
            S_LOAD_B: begin
                thresh_o    = b_q;
                thresh_ce_o = CE_B;
                state_d     = S_COMMIT;
            end
            S_COMMIT: begin
                update_o = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BEAM_SCALER_EN
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HO_LOAD =
        (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

    logic                   commit, mask;
    logic [HW-1:0]          ho_q;
    logic                   win_q, win_last;
    logic [PERIOD_BITS-1:0] per_q, tmr_q;
    logic [1:0]             trig_m;
    logic [CNT_BITS-1:0]    sum_a, sum_b;

    // the commit cycle itself is the first masked cycle
    assign commit   = (state_q == S_COMMIT);
    assign mask     = (commit && (HOLDOFF > 0)) || (ho_q != '0);
    assign win_last = win_q && (tmr_q == per_q - 24'd1);
    assign trig_m   = (win_q && !mask) ? trigger_i : 2'b00;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ho_q <= '0;
        end else if (commit) begin
            ho_q <= HO_LOAD;
        end else if (ho_q != '0) begin
            ho_q <= ho_q - HW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q         <= 1'b0;
            per_q         <= '0;
            tmr_q         <= '0;
            count_a_o     <= '0;
            count_b_o     <= '0;
            count_valid_o <= 1'b0;
        end else begin
            count_valid_o <= win_last;
            if (win_last) begin
                count_a_o <= sum_a;
                count_b_o <= sum_b;
            end
            if (!win_q || win_last) begin
                if (period_i != '0) begin
                    win_q <= 1'b1;
                    per_q <= period_i;
                    tmr_q <= '0;
                end else begin
                    win_q <= 1'b0;
                end
            end else begin
                tmr_q <= tmr_q + 24'd1;
            end
        end
    end

    beam_trig_scaler #(.CNT_BITS(CNT_BITS)) u_scaler_a (
        .clk    (clk_i),
        .rst_i  (rst_i),
        .en_i   (win_q),
        .trig_i (trig_m[1]),
        .clr_i  (win_last),
        .sum_o  (sum_a)
    );

    beam_trig_scaler #(.CNT_BITS(CNT_BITS)) u_scaler_b (
        .clk    (clk_i),
        .rst_i  (rst_i),
        .en_i   (win_q),
        .trig_i (trig_m[0]),
        .clr_i  (win_last),
        .sum_o  (sum_b)
    );
`else
    logic unused_scaler_in;

    assign unused_scaler_in = ^{trigger_i, period_i};
    assign count_a_o        = '0;
    assign count_b_o        = '0;
    assign count_valid_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dual_beam_thresh_ctrl.sv
// Randomized self-checking bench for dual_beam_thresh_ctrl against a
// cycle-offset reference model (scaler checks follow BEAM_SCALER_EN).
module tb_dual_beam_thresh_ctrl;

    localparam int TB = 18;
    localparam int CB = 8;
    localparam int HO = 8;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [TB-1:0] req_thresh_a_i, req_thresh_b_i;
    logic [TB-1:0] thresh_o;
    logic [1:0]    thresh_ce_o;
    logic          update_o;
    logic [1:0]    trigger_i;
    logic [23:0]   period_i;
    logic [CB-1:0] count_a_o, count_b_o;
    logic          count_valid_o;

    dual_beam_thresh_ctrl #(
        .THRESH_BITS (TB),
        .CNT_BITS    (CB),
        .HOLDOFF     (HO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_thresh_a_i (req_thresh_a_i),
        .req_thresh_b_i (req_thresh_b_i),
        .thresh_o       (thresh_o),
        .thresh_ce_o    (thresh_ce_o),
        .update_o       (update_o),
        .trigger_i      (trigger_i),
        .period_i       (period_i),
        .count_a_o      (count_a_o),
        .count_b_o      (count_b_o),
        .count_valid_o  (count_valid_o)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail = 0;

    // reference model state: sequence position is cycle offset from accept
    int          cyc = 0;
    bit          have = 0;
    int          acc_cyc = 0;
    logic [TB-1:0] qa = '0, qb = '0, last = '0;
    int          mask_until = -1;
    bit          w_on = 0;
    int          w_len = 0, w_pos = 0;
    int          ca = 0, cb = 0;
    bit          e_valid = 0;
    int          e_ca = 0, e_cb = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int phase();
        return have ? (cyc - acc_cyc) : 99;
    endfunction

    task automatic model_step();
        int d;
        d = phase();
        if (rst_i) begin
            have = 0;
            last = '0;
            mask_until = -1;
            w_on = 0;
            ca = 0;
            cb = 0;
            e_valid = 0;
            e_ca = 0;
            e_cb = 0;
        end else begin
            if (d == 2) last = qb;
            if (d == 3) mask_until = cyc + HO - 1;
            if (req_valid_i && !(d >= 1 && d <= 3)) begin
                have = 1;
                acc_cyc = cyc;
                qa = req_thresh_a_i;
                qb = req_thresh_b_i;
            end
`ifdef BEAM_SCALER_EN
            e_valid = 0;
            if (!w_on) begin
                if (period_i != 0) begin
                    w_on = 1;
                    w_len = int'(period_i);
                    w_pos = 0;
                end
            end else begin
                if (cyc > mask_until) begin
                    if (trigger_i[1] && ca < CMAX) ca++;
                    if (trigger_i[0] && cb < CMAX) cb++;
                end
                w_pos++;
                if (w_pos == w_len) begin
                    e_valid = 1;
                    e_ca = ca;
                    e_cb = cb;
                    ca = 0;
                    cb = 0;
                    if (period_i != 0) begin
                        w_len = int'(period_i);
                        w_pos = 0;
                    end else begin
                        w_on = 0;
                    end
                end
            end
`endif
        end
        cyc++;
    endtask

    task automatic check_outs();
        int d;
        logic [TB-1:0] et;
        logic [1:0] ece;
        logic eu, er;
        d = phase();
        et = last;
        ece = 2'b00;
        eu = 1'b0;
        if (d == 1) begin
            et = qa;
            ece = 2'b10;
        end else if (d == 2) begin
            et = qb;
            ece = 2'b01;
        end else if (d == 3) begin
            eu = 1'b1;
        end
        er = !(d >= 1 && d <= 3) && !rst_i;
        chk("ready", 32'(req_ready_o), 32'(er));
        chk("thresh", 32'(thresh_o), 32'(et));
        chk("ce", 32'(thresh_ce_o), 32'(ece));
        chk("update", 32'(update_o), 32'(eu));
        chk("cnt_valid", 32'(count_valid_o), 32'(e_valid));
        chk("cnt_a", 32'(count_a_o), 32'(e_ca));
        chk("cnt_b", 32'(count_b_o), 32'(e_cb));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_thresh_a_i = '0;
        req_thresh_b_i = '0;
        trigger_i = 2'b00;
        period_i = '0;
        run(3);
        rst_i = 1'b0;
        run(2);

        // first pair, then a second pair held valid during the sequence
        req_valid_i = 1'b1;
        req_thresh_a_i = 18'd256;
        req_thresh_b_i = 18'd255;
        tick();
        req_thresh_a_i = 18'd10;
        req_thresh_b_i = 18'd20;
        run(4);
        req_valid_i = 1'b0;
        run(6);

        // random mix of requests, triggers and window lengths
        for (int i = 0; i < 500; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0: period_i = 24'd0;
                    1: period_i = 24'd7;
                    2: period_i = 24'd13;
                    default: period_i = 24'd30;
                endcase
            end
            req_valid_i = ($urandom_range(0, 3) == 0);
            req_thresh_a_i = TB'($urandom_range(0, (1 << TB) - 1));
            req_thresh_b_i = TB'($urandom_range(0, (1 << TB) - 1));
            trigger_i = 2'($urandom_range(0, 3));
            tick();
        end
        req_valid_i = 1'b0;

        // steady 100-cycle windows, both beams firing every cycle
        period_i = 24'd100;
        trigger_i = 2'b11;
        run(360);

        // holdoff: one update mid-window removes HO counts
        period_i = 24'd50;
        run(60);
        req_valid_i = 1'b1;
        req_thresh_a_i = 18'd1000;
        req_thresh_b_i = 18'd2000;
        tick();
        req_valid_i = 1'b0;
        run(120);

        // reset while in LOAD_B aborts the commit
        req_valid_i = 1'b1;
        req_thresh_a_i = 18'd77;
        req_thresh_b_i = 18'd88;
        tick();
        req_valid_i = 1'b0;
        run(1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        run(4);

        // saturation of beam A over a long window
        period_i = 24'd300;
        trigger_i = 2'b10;
        run(640);

        // disabling the window stops further strobes
        period_i = 24'd0;
        trigger_i = 2'($urandom_range(0, 3));
        run(320);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
